// File: rtl/cache_lru.sv
// cache_lru: true-LRU replacement state for a set-associative cache.
// Each set holds one age per way; lookup of the oldest way is combinational.
module cache_lru #(
   parameter  int NUM_SET      = 4,
   parameter  int NUM_WAYS     = 16,
   parameter  int WAYS_PER_SET = 4,
   localparam int SW           = (NUM_SET > 1) ? $clog2(NUM_SET) : 1,
   localparam int WW           = (WAYS_PER_SET > 1) ? $clog2(WAYS_PER_SET) : 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          victim_req,
   input  logic [SW-1:0] victim_set,
   output logic [WW-1:0] victim_way,
   input  logic          update_req,
   input  logic [SW-1:0] update_set,
   input  logic [WW-1:0] update_way
);

   if ((NUM_WAYS != NUM_SET * WAYS_PER_SET) ||
       (NUM_SET < 1) || ((NUM_SET & (NUM_SET - 1)) != 0) ||
       (WAYS_PER_SET < 1) || ((WAYS_PER_SET & (WAYS_PER_SET - 1)) != 0)) begin : g_param_check
      $error("cache_lru: inconsistent cache geometry parameters");
   end

   logic [WW-1:0] age [NUM_SET][WAYS_PER_SET];
   logic [WW-1:0] hit_age;
   logic [WW-1:0] lru_way;

   // Old age of the way being touched; it splits the set into ways that move and ways that stay.
   always_comb begin
      hit_age = age[update_set][update_way];
   end

   // Age state: reset order makes way 0 the oldest; an access makes a way youngest.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < NUM_SET; s++) begin
            for (int w = 0; w < WAYS_PER_SET; w++) begin
               age[s][w] <= WW'(WAYS_PER_SET - 1 - w);
            end
         end
      end else if (update_req) begin
         for (int w = 0; w < WAYS_PER_SET; w++) begin
            if (WW'(w) == update_way) begin
               age[update_set][w] <= '0;
            end else if (age[update_set][w] < hit_age) begin
               age[update_set][w] <= age[update_set][w] + WW'(1);
            end else begin
               age[update_set][w] <= age[update_set][w];
            end
         end
      end else begin
         age <= age;
      end
   end

   // Oldest way of the queried set; ages form a permutation so exactly one matches.
   always_comb begin
      lru_way = '0;
      for (int w = 0; w < WAYS_PER_SET; w++) begin
         lru_way = (age[victim_set][w] == WW'(WAYS_PER_SET - 1)) ? WW'(w) : lru_way;
      end
   end

   // Victim port reads zero when no query is active.
   always_comb begin
      if (victim_req) begin
         victim_way = lru_way;
      end else begin
         victim_way = '0;
      end
   end

endmodule

// File: tb/tb_cache_lru.sv
// Self-checking bench for cache_lru: directed scenarios plus random traffic,
// scored against a recency-list model of every set.
module tb_cache_lru;

   localparam int NS  = 4;
   localparam int WPS = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       victim_req = 1'b0;
   logic [1:0] victim_set = 2'd0;
   logic [1:0] victim_way;
   logic       update_req = 1'b0;
   logic [1:0] update_set = 2'd0;
   logic [1:0] update_way = 2'd0;

   int    asserts = 0;
   int    fails   = 0;
   int    exp_q[$];
   string name_q[$];

   // Recency list per set: element 0 is most recently used, last element is LRU.
   int    order [NS][$];

   cache_lru #(.NUM_SET(NS), .NUM_WAYS(NS * WPS), .WAYS_PER_SET(WPS)) dut (
      .clock      (clock),
      .reset      (reset),
      .victim_req (victim_req),
      .victim_set (victim_set),
      .victim_way (victim_way),
      .update_req (update_req),
      .update_set (update_set),
      .update_way (update_way)
   );

   always #5 clock = ~clock;

   function automatic void model_reset();
      for (int s = 0; s < NS; s++) begin
         order[s] = {};
         for (int w = WPS - 1; w >= 0; w--) order[s].push_back(w);
      end
   endfunction

   function automatic void model_touch(input int s, input int w);
      for (int i = 0; i < order[s].size(); i++) begin
         if (order[s][i] == w) begin
            order[s].delete(i);
            break;
         end
      end
      order[s].push_front(w);
   endfunction

   function automatic int model_lru(input int s);
      return order[s][order[s].size() - 1];
   endfunction

   // One cycle of stimulus; want < 0 takes the expectation from the model.
   task automatic step(input bit rst, input bit vr, input int vs,
                       input bit ur, input int us, input int uw,
                       input int want, input string nm);
      int e;
      @(posedge clock);
      #1;
      reset      = rst;
      victim_req = vr;
      victim_set = 2'(vs);
      update_req = ur;
      update_set = 2'(us);
      update_way = 2'(uw);
      if (want >= 0) e = want;
      else           e = vr ? model_lru(vs) : 0;
      exp_q.push_back(e);
      name_q.push_back(nm);
      if (rst)     model_reset();
      else if (ur) model_touch(us, uw);
   endtask

   // Monitor: the victim port is live every cycle, so compare once per cycle mid-period.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         int    e;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         asserts++;
         if (victim_way !== 2'(e)) begin
            fails++;
            $display("FAIL %s: victim_way=%0d expected %0d at %0t", n, victim_way, e, $time);
         end
      end
   end

   initial begin
      model_reset();
      step(1, 0, 0, 0, 0, 0, 0, "reset_idle");
      step(1, 0, 0, 0, 0, 0, 0, "reset_idle");

      // Post-reset fill order in set 2.
      step(0, 1, 2, 0, 0, 0, 0, "fill_first");
      for (int w = 0; w < 3; w++) step(0, 1, 2, 1, 2, w, -1, "fill_seq");
      step(0, 1, 2, 0, 0, 0, 3, "fill_after3");
      step(0, 0, 0, 1, 2, 3, 0, "fill_way3");
      step(0, 1, 2, 0, 0, 0, 0, "fill_wrap");

      // LRU reordering in set 1.
      for (int w = 0; w < 4; w++) step(0, 0, 0, 1, 1, w, 0, "reorder_upd");
      step(0, 0, 0, 1, 1, 0, 0, "reorder_upd");
      step(0, 1, 1, 0, 0, 0, 1, "reorder_lru1");
      step(0, 0, 0, 1, 1, 1, 0, "reorder_upd");
      step(0, 1, 1, 0, 0, 0, 2, "reorder_lru2");

      // Set isolation.
      for (int i = 0; i < 8; i++) step(0, 1, 3, 1, 0, i % 4, -1, "iso_upd");
      step(0, 1, 3, 0, 0, 0, 0, "iso_set3");
      step(0, 1, 0, 0, 0, 0, 0, "iso_set0");

      // Same-cycle query and update of one set.
      step(1, 0, 0, 0, 0, 0, 0, "reset_idle");
      step(0, 1, 0, 1, 0, 0, 0, "same_cycle_pre");
      step(0, 1, 0, 0, 0, 0, 1, "same_cycle_post");

      // Re-accessing the MRU way leaves the order alone.
      for (int w = 0; w < 3; w++) step(0, 1, 3, 1, 3, w, -1, "mru_fill");
      step(0, 1, 3, 1, 3, 3, 3, "mru_fill_last");
      for (int i = 0; i < 3; i++) step(0, 1, 3, 1, 3, 3, 0, "mru_repeat");
      step(0, 1, 3, 0, 0, 0, 0, "mru_after");

      // Reset mid-operation overrides a simultaneous update.
      for (int i = 0; i < 24; i++)
         step(0, 1, $urandom_range(3), 1, $urandom_range(3), $urandom_range(3), -1, "scramble");
      step(1, 0, 0, 1, 1, 0, 0, "reset_with_upd");
      for (int s = 0; s < NS; s++) step(0, 1, s, 0, 0, 0, 0, "post_reset_set");
      step(0, 0, 2, 0, 0, 0, 0, "no_req_zero");

      // Random traffic against the model.
      for (int i = 0; i < 400; i++)
         step(($urandom_range(49) == 0), $urandom_range(1), $urandom_range(3),
              $urandom_range(1), $urandom_range(3), $urandom_range(3), -1, "random");

      step(0, 0, 0, 0, 0, 0, 0, "drain");
      @(posedge clock);
      @(posedge clock);
      asserts++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
